apb_slave_regfile: RTL and testbench
====================================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of wait cycles inserted in each access phase before PREADY is asserted (range 0..15).
REQ-002 Parameter RESET_VAL, default 16'h0000: reset value of data registers 0..6.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 res  input  1  reset; asynchronous, active-high.
REQ-005 PSEL  input  1  slave select from the AXI-to-APB bridge.
REQ-006 PENABLE  input  1  APB access-phase strobe.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  3  register index 0..7.
REQ-009 PWDATA  input  16  write data.
REQ-010 PRDATA  output  16  read data.
REQ-011 PREADY  output  1  transfer-complete strobe.

Function
REQ-012 The block SHALL hold eight 16-bit locations: 0..6 are read/write data registers; 7 is a read-only status register, STATUS = {8'h00, wr_count[7:0]}.
REQ-013 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
- IDLE -> SETUP when PSEL=1 and PENABLE=0.
- SETUP -> ACCESS when PSEL=1 and PENABLE=1.
- ACCESS -> IDLE when PREADY=1.
- Any state -> IDLE when PSEL=0.
REQ-014 On the SETUP->ACCESS edge the wait counter SHALL load WAIT_CYCLES; in ACCESS it SHALL decrement once per cycle while nonzero.
REQ-015 PREADY SHALL equal (state==ACCESS && cnt==0 && PSEL && PENABLE); with WAIT_CYCLES=N it asserts in the (N+1)th access-phase cycle.
REQ-016 Write commit: at the clock edge where PSEL&PENABLE&PREADY&PWRITE=1, register[PADDR] <= PWDATA for PADDR 0..6, and wr_count increments by one.
REQ-017 Writes to PADDR=7 SHALL complete normally (PREADY asserted) and SHALL leave STATUS unchanged; wr_count SHALL NOT increment.
REQ-018 wr_count SHALL be 8 bits and wrap 8'hFF -> 8'h00.
REQ-019 Read data: PRDATA SHALL equal location[PADDR] while PREADY=1 and PWRITE=0; otherwise PRDATA SHALL be 16'h0000.
REQ-020 Address, data and direction SHALL be sampled during the PREADY=1 cycle; mid-transfer PADDR changes are not checked.
REQ-021 Abort: PSEL falling in SETUP or ACCESS before PREADY SHALL return the FSM to IDLE with no register or wr_count update.
REQ-022 Back-to-back transfers: PSEL held high and PENABLE low in the cycle after PREADY SHALL go IDLE->SETUP directly, with no dead cycle.

Reset
REQ-023 While res=1: state=IDLE, cnt=0, registers 0..6=RESET_VAL, wr_count=0, PREADY=0, PRDATA=16'h0000, independent of clk.
REQ-024 Reset asserted mid-access SHALL discard the transfer; after res falls, the next transfer SHALL begin with a fresh SETUP.

Configuration
REQ-025 Macro APB_SLV_WAIT_EN: when defined, the wait counter and WAIT_CYCLES behave as in REQ-014/015.
REQ-026 When APB_SLV_WAIT_EN is undefined, the counter SHALL NOT exist, WAIT_CYCLES SHALL be ignored, and PREADY SHALL equal (state==ACCESS && PSEL && PENABLE), giving zero wait states.

Structure
REQ-027 Package apb_slv_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS), DATA_W=16, ADDR_W=3, NUM_REGS=8 and STATUS_ADDR=3'd7.
REQ-028 One sub-module, apb_slv_waitcnt, SHALL implement the loadable down-counter and its zero flag; it is instantiated only under APB_SLV_WAIT_EN.

Verification
REQ-029 Write 16'hA5A5 to addr 3 with WAIT_CYCLES=2, then read addr 3 -> PREADY high in the 3rd access cycle of each transfer; PRDATA=16'hA5A5; STATUS=16'h0001.
REQ-030 Write 16'h1234 to addr 7, then read addr 7 -> STATUS unchanged (16'h0000 after reset); PREADY still asserted on the write.
REQ-031 Drop PSEL in the 1st access cycle of a write of 16'hFFFF to addr 0 -> addr 0 reads RESET_VAL; wr_count=0.
REQ-032 256 writes to addr 1 -> STATUS=16'h0000 (wrap); addr 1 holds the last data written.
REQ-033 Assert res during the access phase of a write to addr 2 -> PREADY and PRDATA drop immediately; addr 2 reads RESET_VAL after reset.
REQ-034 Build without APB_SLV_WAIT_EN; run back-to-back reads of addrs 0..6 -> PREADY high in every access cycle; no idle cycle between transfers.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB slave register file.
package apb_slv_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 3;
    localparam int NUM_REGS    = 8;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 3'd7;

    // Bus-side FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slv_waitcnt.sv
// Loadable 4-bit down-counter with zero flag; paces PREADY during ACCESS.
module apb_slv_waitcnt (
    input  logic       clk,
    input  logic       res,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_r;

    // Load on entry to ACCESS, then count down to zero and hold there.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with seven 16-bit R/W registers and a read-only write counter
// at address 7. Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states
// per transfer; without it every transfer completes with zero wait states.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter logic [3:0]        WAIT_CYCLES = 4'd2,
    parameter logic [DATA_W-1:0] RESET_VAL   = 16'h0000
) (
    input  logic              clk,
    input  logic              res,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY
);

    localparam int NUM_DATA_REGS = NUM_REGS - 1;

    apb_state_e        state_r;
    logic [7:0]        wr_count_r;
    logic [DATA_W-1:0] regs_r [NUM_DATA_REGS];
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] rdata_s;
    logic              pready_s;
    logic              commit_s;

`ifdef APB_SLV_WAIT_EN
    logic cnt_zero_s;

    apb_slv_waitcnt u_waitcnt (
        .clk      (clk),
        .res      (res),
        .load     ((state_r == SETUP) && PSEL && PENABLE),
        .dec      (state_r == ACCESS),
        .load_val (WAIT_CYCLES),
        .zero     (cnt_zero_s)
    );

    assign pready_s = (state_r == ACCESS) && cnt_zero_s && PSEL && PENABLE;
`else
    // WAIT_CYCLES has no effect in the zero-wait build.
    logic unused_wait_s;
    assign unused_wait_s = |WAIT_CYCLES;

    assign pready_s = (state_r == ACCESS) && PSEL && PENABLE;
`endif

    assign commit_s = PSEL && PENABLE && pready_s && PWRITE;
    assign status_s = {8'h00, wr_count_r};

    // Transfer sequencing; dropping PSEL aborts from any state.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (PSEL && !PENABLE) state_r <= SETUP;
                    else                  state_r <= IDLE;
                end
                SETUP: begin
                    if (!PSEL)        state_r <= IDLE;
                    else if (PENABLE) state_r <= ACCESS;
                    else              state_r <= SETUP;
                end
                ACCESS: begin
                    if (!PSEL || pready_s) state_r <= IDLE;
                    else                   state_r <= ACCESS;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Write commit; writes to the status address complete but change nothing.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NUM_DATA_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
            wr_count_r <= 8'd0;
        end else if (commit_s && (PADDR != STATUS_ADDR)) begin
            regs_r[PADDR] <= PWDATA;
            wr_count_r    <= wr_count_r + 8'd1;
        end
    end

    // Read data is driven only during the completing cycle of a read.
    always_comb begin
        rdata_s = 16'h0000;
        if (pready_s && !PWRITE) begin
            if (PADDR == STATUS_ADDR) rdata_s = status_s;
            else                      rdata_s = regs_r[PADDR];
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign PRDATA = rdata_s;
    assign PREADY = pready_s;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed self-checking bench for apb_slave_regfile.
module tb_apb_slave_regfile;

    localparam logic [15:0] RST_V = 16'h5A00;
`ifdef APB_SLV_WAIT_EN
    localparam int ACC_EXP = 3;   // WAIT_CYCLES=2 -> ready in 3rd ACCESS cycle
`else
    localparam int ACC_EXP = 1;
`endif

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [2:0]  PADDR = 3'd0;
    logic [15:0] PWDATA = 16'h0000;
    logic [15:0] PRDATA;
    logic        PREADY;

    int errors = 0;
    int checks = 0;

    apb_slave_regfile #(.WAIT_CYCLES(4'd2), .RESET_VAL(RST_V)) dut (
        .clk(clk), .res(res), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns PRDATA and the ACCESS-cycle index of PREADY
    // (PENABLE cycles minus the one spent while the slave is in SETUP).
    task automatic xfer(input logic wr, input logic [2:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output int acc, output logic [15:0] wr_rd);
        int pen;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        pen = 1;
        while (PREADY !== 1'b1 && pen < 40) begin
            @(posedge clk); #1;
            pen++;
        end
        rdata = PRDATA;
        wr_rd = PRDATA;
        acc = (pen >= 40) ? 99 : pen - 1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] wrd;
        int          acc;

        // Reset state
        #2 res = 1'b1;
        #1;
        check("rst_pready", {15'd0, PREADY}, 16'h0000);
        check("rst_prdata", PRDATA, 16'h0000);
        repeat (2) @(posedge clk);
        #1 res = 1'b0;

        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("status_after_reset", rd, 16'h0000);
        idle();

        // Write to status address: completes, no effect
        xfer(1'b1, 3'd7, 16'h1234, rd, acc, wrd);
        check("wr7_latency", 16'(acc), 16'(ACC_EXP));
        check("wr7_prdata_zero_on_write", wrd, 16'h0000);
        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("rd7_unchanged", rd, 16'h0000);
        idle();
        check("idle_prdata", PRDATA, 16'h0000);

        // Basic write/read with wait states
        xfer(1'b1, 3'd3, 16'hA5A5, rd, acc, wrd);
        check("wr3_latency", 16'(acc), 16'(ACC_EXP));
        xfer(1'b0, 3'd3, 16'h0000, rd, acc, wrd);
        check("rd3_latency", 16'(acc), 16'(ACC_EXP));
        check("rd3_data", rd, 16'hA5A5);
        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("status_one", rd, 16'h0001);
        idle();

        // Abort: PSEL drops in the first ACCESS cycle
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd0; PWDATA = 16'hFFFF;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        PSEL = 1'b0;
        #1;
        check("abort_pready", {15'd0, PREADY}, 16'h0000);
        idle();
        xfer(1'b0, 3'd0, 16'h0000, rd, acc, wrd);
        check("abort_addr0", rd, RST_V);
        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("abort_status", rd, 16'h0001);

        // Reset asserted while a write to addr 2 is completing
        xfer(1'b1, 3'd2, 16'h1111, rd, acc, wrd);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd2; PWDATA = 16'hBEEF;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 20 && PREADY !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_pready", {15'd0, PREADY}, 16'h0001);
        res = 1'b1;
        #1;
        check("midreset_pready", {15'd0, PREADY}, 16'h0000);
        check("midreset_prdata", PRDATA, 16'h0000);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; res = 1'b0;
        xfer(1'b0, 3'd2, 16'h0000, rd, acc, wrd);
        check("post_reset_latency", 16'(acc), 16'(ACC_EXP));
        check("post_reset_addr2", rd, RST_V);
        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("post_reset_status", rd, 16'h0000);
        idle();

        // 256 writes: counter wraps to zero
        for (int i = 0; i < 256; i++) begin
            xfer(1'b1, 3'd1, 16'h0100 + 16'(i), rd, acc, wrd);
        end
        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("wrap_status", rd, 16'h0000);
        xfer(1'b0, 3'd1, 16'h0000, rd, acc, wrd);
        check("wrap_addr1", rd, 16'h01FF);
        idle();

        // Back-to-back writes then reads of all data registers
        for (int i = 0; i < 7; i++) begin
            xfer(1'b1, 3'(i), 16'hC000 + 16'(i * 16'h0111), rd, acc, wrd);
            check($sformatf("b2b_wr%0d_latency", i), 16'(acc), 16'(ACC_EXP));
        end
        for (int i = 0; i < 7; i++) begin
            xfer(1'b0, 3'(i), 16'h0000, rd, acc, wrd);
            check($sformatf("b2b_rd%0d_latency", i), 16'(acc), 16'(ACC_EXP));
            check($sformatf("b2b_rd%0d_data", i), rd, 16'hC000 + 16'(i * 16'h0111));
        end
        xfer(1'b0, 3'd7, 16'h0000, rd, acc, wrd);
        check("b2b_status", rd, 16'h0007);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
